// File: rtl/serial_port_pkg.sv
// Shared definitions for the MCU51 mode-1 UART: SCON bit positions,
// FSM state encoding and the default bit period.
package serial_port_pkg;

  // 9600 baud from a 12 MHz XTAL1
  localparam int CLKS_PER_BIT_DEF = 1250;

  // SCON = {SM0,SM1,SM2,REN,TB8,RB8,TI,RI}
  localparam int SCON_RI  = 0;
  localparam int SCON_TI  = 1;
  localparam int SCON_RB8 = 2;
  localparam int SCON_TB8 = 3;
  localparam int SCON_REN = 4;
  localparam int SCON_SM2 = 5;
  localparam int SCON_SM1 = 6;
  localparam int SCON_SM0 = 7;

  // Common encoding for the TX and RX frame FSMs
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer. Held at zero while start=1; otherwise counts and
// pulses tick on the last cycle of a bit (or of a half bit when half=1),
// reloading to zero so the next period begins on the following cycle.
module serial_bit_timer
  import serial_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic half,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Terminal-count detect and next count
  always_comb begin
    tick  = !start && (cnt_q == (half ? HALF_LAST : FULL_LAST));
    cnt_d = cnt_q + 1'b1;
    if (start || tick) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_port.sv
// MCU51 serial port, mode 1 (8-N-1): SBUF/SCON on the internal bus,
// TX shifter on txd, mid-bit sampling receiver on rxd, TI/RI flags.
module serial_port
  import serial_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       sbuf_en,
  input  logic       sbuf_oe,
  input  logic       scon_en,
  input  logic       scon_oe,
  input  logic       rxd,
  output logic       txd,
  output logic       ti,
  output logic       ri,
  output logic       tx_busy
);

  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bits_q, tx_bits_d;
  logic        tx_tick, ti_set;

  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bits_q, rx_bits_d;
  logic [7:0]  rx_sbuf_q, rx_sbuf_d;
  logic        rx_tick, rx_load, rx_fall, ren;

  // rxd_s1/s2 form the synchroniser; rxd_s3 is s2 delayed for edge detect
  logic rxd_s1_q, rxd_s2_q, rxd_s3_q;

  logic [7:0] scon_q, scon_d;

  assign ren     = scon_q[SCON_REN];
  assign rx_fall = rxd_s3_q & ~rxd_s2_q;

  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk   (clk),
    .reset (reset),
    .start (tx_state_q == ST_IDLE),
    .half  (1'b0),
    .tick  (tx_tick)
  );

  // RX timer waits half a bit in START to land on mid-bit, full bits after
  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk   (clk),
    .reset (reset),
    .start (rx_state_q == ST_IDLE),
    .half  (rx_state_q == ST_START),
    .tick  (rx_tick)
  );

  // TX FSM: load on SBUF write in IDLE, shift LSB first, flag TI at stop end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    ti_set     = 1'b0;
    unique case (tx_state_q)
      ST_IDLE: if (sbuf_en) begin
        tx_shift_d = din;
        tx_bits_d  = '0;
        tx_state_d = ST_START;
      end
      ST_START: if (tx_tick) tx_state_d = ST_DATA;
      ST_DATA: if (tx_tick) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bits_d  = tx_bits_q + 3'd1;
        if (tx_bits_q == 3'd7) tx_state_d = ST_STOP;
      end
      ST_STOP: if (tx_tick) begin
        ti_set     = 1'b1;
        tx_state_d = ST_IDLE;
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  assign txd = (tx_state_q == ST_START) ? 1'b0 :
               (tx_state_q == ST_DATA)  ? tx_shift_q[0] : 1'b1;
  assign tx_busy = (tx_state_q != ST_IDLE);

  // RX FSM: start on falling edge, verify start at half bit, sample mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bits_d  = rx_bits_q;
    rx_load    = 1'b0;
    if (!ren) begin
      rx_state_d = ST_IDLE;
    end else begin
      unique case (rx_state_q)
        ST_IDLE: if (rx_fall) rx_state_d = ST_START;
        ST_START: if (rx_tick) begin
          if (rxd_s2_q) begin
            rx_state_d = ST_IDLE;          // glitch, not a real start bit
          end else begin
            rx_bits_d  = '0;
            rx_state_d = ST_DATA;
          end
        end
        ST_DATA: if (rx_tick) begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_bits_d  = rx_bits_q + 3'd1;
          if (rx_bits_q == 3'd7) rx_state_d = ST_STOP;
        end
        ST_STOP: if (rx_tick) begin
          // Keep an unread byte (overrun) and honour the SM2 stop filter
          rx_load    = !scon_q[SCON_RI] && (!scon_q[SCON_SM2] || rxd_s2_q);
          rx_state_d = ST_IDLE;
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end
  end

  // Receive buffer and SCON; hardware flag sets override a same-cycle write
  always_comb begin
    rx_sbuf_d = rx_load ? rx_shift_q : rx_sbuf_q;
    scon_d    = scon_q;
    if (scon_en) scon_d = din;
    if (ti_set)  scon_d[SCON_TI] = 1'b1;
    if (rx_load) begin
      scon_d[SCON_RI]  = 1'b1;
      scon_d[SCON_RB8] = rxd_s2_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_shift_q <= '0;
      tx_bits_q  <= '0;
      rx_state_q <= ST_IDLE;
      rx_shift_q <= '0;
      rx_bits_q  <= '0;
      rx_sbuf_q  <= '0;
      scon_q     <= '0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_s3_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bits_q  <= rx_bits_d;
      rx_sbuf_q  <= rx_sbuf_d;
      scon_q     <= scon_d;
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_s3_q   <= rxd_s2_q;
    end
  end

  assign ti = scon_q[SCON_TI];
  assign ri = scon_q[SCON_RI];

  // SCON wins if the control unit ever enables both readers
  assign dout = scon_oe ? scon_q : (sbuf_oe ? rx_sbuf_q : 8'hzz);

endmodule
